// File: rtl/ib_lut_ctrl_pkg.sv
// Purpose: shared types and default geometry for the IB-DNU LUT update controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ib_lut_ctrl_pkg;

  // Default LUT geometry; the top exposes these as overridable parameters.
  localparam int DEF_ENTRY_ADDR      = 7;
  localparam int DEF_MULTI_FRAME_NUM = 2;
  localparam int DEF_BANK_NUM        = 2;
  localparam int DEF_LUT_PORT_SIZE   = 1;
  localparam int DEF_PAGE_NUM        = 64;

  // Derived widths for the default geometry.
  localparam int PAGE_ADDR_W = DEF_ENTRY_ADDR - 1;
  localparam int LUT_WORD_W  = DEF_LUT_PORT_SIZE * DEF_BANK_NUM;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } upd_state_e;

endpackage

// File: rtl/ib_lut_page_cnt.sv
// Purpose: wrapping page counter for the LUT image load (clear, increment, last flag).
// Latency: count updates 1 cycle after clr/inc; last is combinational from the count.
// Backpressure: none; the caller gates inc with the accepted-beat strobe.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clr        - force the count to 0 (wins over inc)
//   inc        - advance by one, wrapping to 0 after PAGE_NUM-1
//   cnt        - current page index
//   last       - cnt == PAGE_NUM-1
module ib_lut_page_cnt #(
  parameter int W        = 6,
  parameter int PAGE_NUM = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last = (cnt_q == W'(PAGE_NUM - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      // PAGE_NUM need not be a power of two, so wrap explicitly.
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ib_dnu_lut_update_ctrl.sv
// Purpose: streams one LUT image into the frame the decoder is not reading, then flips
//          read_addr_offset at the next iteration boundary (ping-pong LUT reconfiguration).
// Latency: accepted beat -> RAM write exactly 1 cycle; boundary -> swap/update_done 1 cycle.
// Backpressure: lut_ready is high only in LOAD; outside LOAD no beats are taken.
//
// Ports:
//   write_clk, rst       - sole clock, asynchronous active-high reset
//   update_start         - request a new image load (ignored with busy_err while busy)
//   update_abort         - cancel a load in progress (also vetoes a same-cycle start)
//   iter_boundary        - decoder end-of-iteration pulse; only acted on in WAIT_SWAP
//   lut_valid/lut_ready  - page handshake; lut_data upper half is bank0
//   page_addr_ram        - {write frame, page index}
//   ram_write_data_1     - registered page data
//   ib_ram_we            - RAM write enable
//   read_addr_offset     - active read frame
//   busy, update_done, busy_err - status
module ib_dnu_lut_update_ctrl
  import ib_lut_ctrl_pkg::*;
#(
  parameter int ENTRY_ADDR      = DEF_ENTRY_ADDR,
  parameter int MULTI_FRAME_NUM = DEF_MULTI_FRAME_NUM,
  parameter int BANK_NUM        = DEF_BANK_NUM,
  parameter int LUT_PORT_SIZE   = DEF_LUT_PORT_SIZE,
  parameter int PAGE_NUM        = DEF_PAGE_NUM
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              update_start,
  input  logic                              update_abort,
  input  logic                              iter_boundary,
  input  logic                              lut_valid,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] lut_data,
  output logic                              lut_ready,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
  output logic                              ib_ram_we,
  output logic                              read_addr_offset,
  output logic                              busy,
  output logic                              update_done,
  output logic                              busy_err
);

  localparam int PAW = ENTRY_ADDR - 1;
  localparam int LW  = LUT_PORT_SIZE * BANK_NUM;

  // The frame offset is a single address bit, so only ping-pong is supported.
  if (MULTI_FRAME_NUM != 2) begin : g_bad_frames
    $error("ib_dnu_lut_update_ctrl supports exactly 2 LUT frames");
  end
  if (PAGE_NUM > (1 << PAW)) begin : g_bad_pages
    $error("PAGE_NUM does not fit in the page address field");
  end

  upd_state_e           state_q, state_d;
  logic                 wr_off_q, wr_off_d;
  logic                 we_q, we_d;
  logic [ENTRY_ADDR-1:0] addr_q, addr_d;
  logic [LW-1:0]        data_q, data_d;
  logic                 rd_off_q, rd_off_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 cnt_clr;
  logic                 cnt_inc;
  logic [PAW-1:0]       cnt;
  logic                 cnt_last;
  logic                 accept;

  ib_lut_page_cnt #(
    .W        (PAW),
    .PAGE_NUM (PAGE_NUM)
  ) u_page_cnt (
    .clk  (write_clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .last (cnt_last)
  );

  assign lut_ready = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = lut_valid & lut_ready;

  always_comb begin
    state_d  = state_q;
    wr_off_d = wr_off_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_off_d = rd_off_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Abort vetoes a coincident start.
        if (update_start && !update_abort) begin
          wr_off_d = ~rd_off_q;
          cnt_clr  = 1'b1;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        err_d = update_start;
        if (update_abort) begin
          // Any beat handshaked this cycle is dropped: no write, no count.
          state_d = ST_IDLE;
        end else if (accept) begin
          we_d    = 1'b1;
          addr_d  = {wr_off_q, cnt};
          data_d  = lut_data;
          cnt_inc = 1'b1;
          // A boundary coinciding with the last accept is ignored here, so the
          // swap always waits for a later boundary after the final write lands.
          if (cnt_last) begin
            state_d = ST_WAIT_SWAP;
          end
        end
      end

      ST_WAIT_SWAP: begin
        err_d = update_start;
        if (update_abort) begin
          state_d = ST_IDLE;
        end else if (iter_boundary) begin
          rd_off_d = ~rd_off_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_off_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rd_off_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_off_q <= wr_off_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_off_q <= rd_off_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign page_addr_ram    = addr_q;
  assign ram_write_data_1 = data_q;
  assign ib_ram_we        = we_q;
  assign read_addr_offset = rd_off_q;
  assign update_done      = done_q;
  assign busy_err         = err_q;

endmodule
